// File: rtl/shift299_if.sv
// ---------------------------------------------------------------------------
// shift299_if
// Command / register-bus bundle between a requester, the shift299_ctrl
// controller and a '299-style universal shift register.
//   Requester -> controller : req, op, cnt, din, sin
//   Register  -> controller : io_in (register parallel outputs)
//   Controller -> register  : s, n_oe, dsr, dsl, io_drv, io_out
//   Controller -> requester : dout, ack, busy
// The slave modport is the controller view; the master modport is the
// requester / register-model view used by the environment.
// ---------------------------------------------------------------------------
interface shift299_if;
    logic       req;
    logic [1:0] op;
    logic [2:0] cnt;
    logic [7:0] din;
    logic       sin;
    logic [7:0] io_in;
    logic [1:0] s;
    logic       n_oe;
    logic       dsr;
    logic       dsl;
    logic       io_drv;
    logic [7:0] io_out;
    logic [7:0] dout;
    logic       ack;
    logic       busy;

    modport slave (
        input  req, op, cnt, din, sin, io_in,
        output s, n_oe, dsr, dsl, io_drv, io_out, dout, ack, busy
    );

    modport master (
        output req, op, cnt, din, sin, io_in,
        input  s, n_oe, dsr, dsl, io_drv, io_out, dout, ack, busy
    );
endinterface

// File: rtl/shift299_ctrl.sv
// ---------------------------------------------------------------------------
// shift299_ctrl
// Sequencer for a '299-style 8-bit universal shift register. Accepts one
// command at a time (load, shift right, shift left, read) and drives the
// register mode pins, serial fill inputs, output enable and the shared IO bus.
// Ports:
//   cp_i  : rising-edge clock, the only clock
//   mr_i  : synchronous active-high master reset, aborts any command
//   bus   : shift299_if.slave (command handshake + register bus)
// ---------------------------------------------------------------------------
module shift299_ctrl (
    input  logic      cp_i,
    input  logic      mr_i,
    shift299_if.slave bus
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_LEFT  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_READ1 = 3'd3,
        ST_READ2 = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] io_out_q, io_out_d;
    logic [7:0] dout_q, dout_d;

    logic [1:0] s_s;
    logic       n_oe_s;
    logic       io_drv_s;
    logic       ack_s;
    logic       busy_s;
    logic       dsr_s;
    logic       dsl_s;

    // State and datapath registers with synchronous master reset.
    always_ff @(posedge cp_i) begin
        if (mr_i) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'b00;
            cnt_q    <= 4'd0;
            io_out_q <= 8'h00;
            dout_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            io_out_q <= io_out_d;
            dout_q   <= dout_d;
        end
    end

    // Next-state and datapath update; command inputs only matter in IDLE.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        io_out_d = io_out_q;
        dout_d   = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    op_d  = bus.op;
                    // A count of zero means a full byte (8 shifts).
                    cnt_d = (bus.cnt == 3'd0) ? 4'd8 : {1'b0, bus.cnt};
                    // IO_OUT only follows DIN for loads so it keeps the
                    // last loaded value across other commands.
                    if (bus.op == OP_LOAD) begin
                        io_out_d = bus.din;
                    end else begin
                        io_out_d = io_out_q;
                    end
                    case (bus.op)
                        OP_LOAD:  state_d = ST_LOAD;
                        OP_RIGHT: state_d = ST_SHIFT;
                        OP_LEFT:  state_d = ST_SHIFT;
                        OP_READ:  state_d = ST_READ1;
                        default:  state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                // Saturating decrement: the counter never wraps below zero.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                // Exit on the last shift cycle; a zero value (unreachable
                // in normal operation) also exits instead of shifting forever.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_READ1: begin
                state_d = ST_READ2;
            end
            ST_READ2: begin
                // Register outputs have had a full cycle to settle.
                dout_d  = bus.io_in;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        s_s      = S_HOLD;
        n_oe_s   = 1'b1;
        io_drv_s = 1'b0;
        ack_s    = 1'b0;
        busy_s   = 1'b1;
        dsr_s    = 1'b0;
        dsl_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_LOAD: begin
                s_s      = S_LOAD;
                io_drv_s = 1'b1;
            end
            ST_SHIFT: begin
                // Mode pins mirror the latched opcode (01 right, 10 left).
                s_s   = op_q;
                dsr_s = (op_q == OP_RIGHT) ? bus.sin : 1'b0;
                dsl_s = (op_q == OP_LEFT)  ? bus.sin : 1'b0;
            end
            ST_READ1: begin
                n_oe_s = 1'b0;
            end
            ST_READ2: begin
                n_oe_s = 1'b0;
            end
            ST_DONE: begin
                ack_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    assign bus.s      = s_s;
    assign bus.n_oe   = n_oe_s;
    assign bus.io_drv = io_drv_s;
    assign bus.ack    = ack_s;
    assign bus.busy   = busy_s;
    assign bus.dsr    = dsr_s;
    assign bus.dsl    = dsl_s;
    assign bus.io_out = io_out_q;
    assign bus.dout   = dout_q;

endmodule
